// File: rtl/prim_scan_pkg.sv
// Shared types and constants for the prime-range scan controller.
package prim_scan_pkg;

  // Candidate width is fixed by the numPrim checker.
  localparam int W      = 4;
  // Counter width; 0..15 holds at most 6 primes.
  localparam int CNT_W  = 3;
  // One mask bit per possible candidate value.
  localparam int MASK_W = 16;

  // Controller states, kept as plain 2-bit constants for legacy compatibility.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DONE = 2'd3;

endpackage

// File: rtl/prim_scan_ctrl_numprim.sv
// Existing 4-bit combinational prime checker: out=1 for 2,3,5,7,11,13.
module numPrim (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic out
);

  // Sum-of-products cover of the six primes below 16.
  assign out = (~a & ~b &  c)       // 2, 3
             | (~a &  b &  d)       // 5, 7
             | ( b & ~c &  d)       // 5, 13
             | (~b &  c &  d);      // 3, 11

endmodule

// File: rtl/prim_scan_ctrl.sv
// Sweeps an inclusive range [lo, hi] through one numPrim checker, one
// candidate per cycle, streaming each prime out on a valid/ready interface
// and accumulating a prime count and a 16-bit prime mask.
module prim_scan_ctrl #(
  parameter int W     = prim_scan_pkg::W,
  parameter int CNT_W = prim_scan_pkg::CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [W-1:0]                 lo,
  input  logic [W-1:0]                 hi,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         prim_valid,
  output logic [W-1:0]                 prim_data,
  input  logic                         prim_ready,
  output logic [CNT_W-1:0]             prim_count,
  output logic [prim_scan_pkg::MASK_W-1:0] prim_mask
);

  import prim_scan_pkg::*;

  state_t         state_reg;
  logic [W-1:0]   cur_reg;     // candidate currently presented to numPrim
  logic [W-1:0]   hi_reg;      // latched end of range
  logic           last_reg;    // the prime in HOLD was the final candidate
  logic           err_reg;     // latched lo > hi, reported with done
  logic           is_prime;

  // The checker sees only the registered candidate, so SCAN decisions are
  // based on a value that was stable for the whole cycle. The start value is
  // loaded straight into cur_reg, so no separate copy of lo is kept.
  numPrim u_num_prim (
    .a   (cur_reg[3]),
    .b   (cur_reg[2]),
    .c   (cur_reg[1]),
    .d   (cur_reg[0]),
    .out (is_prime)
  );

  // Status outputs decode directly from state flops.
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign err  = (state_reg == DONE) & err_reg;

  // Main sequencer: range latch, candidate walk, stream handshake, stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cur_reg    <= '0;
      hi_reg     <= '0;
      last_reg   <= 1'b0;
      err_reg    <= 1'b0;
      prim_valid <= 1'b0;
      prim_data  <= '0;
      prim_count <= '0;
      prim_mask  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            hi_reg     <= hi;
            prim_count <= '0;
            prim_mask  <= '0;
            last_reg   <= 1'b0;
            if (lo > hi) begin
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end else begin
              err_reg   <= 1'b0;
              cur_reg   <= lo;
              state_reg <= SCAN;
            end
          end
        end
        SCAN: begin
          if (is_prime) begin
            prim_data          <= cur_reg;
            prim_valid         <= 1'b1;
            prim_mask[cur_reg] <= 1'b1;
            prim_count         <= prim_count + 1'b1;
            last_reg           <= (cur_reg == hi_reg);
            state_reg          <= HOLD;
          end else if (cur_reg == hi_reg) begin
            // Termination is by compare, so hi=15 never wraps cur to 0.
            state_reg <= DONE;
          end else begin
            cur_reg <= cur_reg + 1'b1;
          end
        end
        HOLD: begin
          if (prim_ready) begin
            prim_valid <= 1'b0;
            if (last_reg) begin
              state_reg <= DONE;
            end else begin
              cur_reg   <= cur_reg + 1'b1;
              state_reg <= SCAN;
            end
          end
        end
        DONE: begin
          // Single-cycle completion; start is not sampled here.
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prim_scan_ctrl.sv
// Self-checking bench for prim_scan_ctrl: directed scenarios from the test
// plan plus randomized ranges and randomized backpressure, checked against a
// trial-division prime model.
module tb_prim_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  lo = 4'd0;
  logic [3:0]  hi = 4'd0;
  logic        prim_ready = 1'b0;
  logic        busy, done, err, prim_valid;
  logic [3:0]  prim_data;
  logic [2:0]  prim_count;
  logic [15:0] prim_mask;

  int errors = 0;
  int checks = 0;

  // Expected results from the model.
  int          exp_q[$];
  int          exp_cnt;
  logic [15:0] exp_mask;
  int          exp_busy;

  // Observations collected by run_scan.
  int          obs_q[$];
  int          busy_cnt, done_cnt, err_cnt, err_alone, stab_err;
  bit          timed_out;
  logic        end_busy;
  logic [2:0]  end_count;
  logic [15:0] end_mask;

  prim_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .lo         (lo),
    .hi         (hi),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .prim_valid (prim_valid),
    .prim_data  (prim_data),
    .prim_ready (prim_ready),
    .prim_count (prim_count),
    .prim_mask  (prim_mask)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k < n; k++) if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Expected stream, count, mask and busy length (ready tied high).
  task automatic model(input int l, input int h);
    exp_q.delete();
    exp_cnt  = 0;
    exp_mask = '0;
    for (int n = l; n <= h; n++) begin
      if (is_prime(n)) begin
        exp_q.push_back(n);
        exp_cnt++;
        exp_mask[n] = 1'b1;
      end
    end
    exp_busy = (l > h) ? 1 : (h - l + 1) + exp_cnt + 1;
  endtask

  function automatic bit stream_ok();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (obs_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Starts a scan and observes it until done. mode 0: ready high,
  // 1: random ready, 2: ready low for 5 cycles after each valid rise.
  // inj_cycle >= 0 pulses start (lo=0, hi=2) on that cycle while busy.
  task automatic run_scan(input int l, input int h, input int mode, input int inj_cycle);
    logic       pv;
    logic [3:0] pd;
    bit         stalled, seen;
    int         low_left;
    obs_q.delete();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0; err_alone = 0; stab_err = 0;
    timed_out = 1'b0; pv = 1'b0; pd = '0; stalled = 1'b0; seen = 1'b0; low_left = 0;
    @(negedge clk);
    start = 1'b1; lo = 4'(l); hi = 4'(h); prim_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == inj_cycle) begin
        start = 1'b1; lo = 4'd0; hi = 4'd2;
      end else begin
        start = 1'b0; lo = 4'($urandom); hi = 4'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (err && !done) err_alone++;
      if (stalled && (prim_valid !== 1'b1 || prim_data !== pd)) stab_err++;
      case (mode)
        0: prim_ready = 1'b1;
        1: prim_ready = 1'($urandom_range(0, 1));
        default: begin
          if (prim_valid && !pv) low_left = 5;
          if (low_left > 0) begin
            prim_ready = 1'b0;
            low_left--;
          end else begin
            prim_ready = 1'b1;
          end
        end
      endcase
      if (prim_valid && prim_ready) obs_q.push_back(int'(prim_data));
      stalled = prim_valid && !prim_ready;
      pd = prim_data;
      pv = prim_valid;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) timed_out = 1'b1;
    @(negedge clk);
    end_busy  = busy;
    end_count = prim_count;
    end_mask  = prim_mask;
    $display("scan lo=%0d hi=%0d mode=%0d primes=%0d count=%0d mask=%h busy=%0d done=%0d err=%0d",
             l, h, mode, obs_q.size(), end_count, end_mask, busy_cnt, done_cnt, err_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, err, prim_valid, prim_data, prim_count, prim_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b valid=%b data=%0d count=%0d mask=%h, required all 0",
               busy, done, err, prim_valid, prim_data, prim_count, prim_mask);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_sweep();
    model(0, 15);
    run_scan(0, 15, 0, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL sweep_timeout: no done within budget"); end
    checks++;
    if (!stream_ok()) begin
      errors++;
      $display("FAIL sweep_stream: got %0d primes, required %0d (2,3,5,7,11,13)", obs_q.size(), exp_q.size());
    end
    checks++;
    if (end_count !== 3'(exp_cnt)) begin errors++; $display("FAIL sweep_count: got %0d required %0d", end_count, exp_cnt); end
    checks++;
    if (end_mask !== 16'h28AC) begin errors++; $display("FAIL sweep_mask: got %h required 28ac", end_mask); end
    checks++;
    if (busy_cnt != exp_busy) begin errors++; $display("FAIL sweep_busy_cycles: got %0d required %0d", busy_cnt, exp_busy); end
    checks++;
    if (done_cnt != 1 || err_cnt != 0 || end_busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_done: got done=%0d err=%0d busy_after=%b required 1 0 0", done_cnt, err_cnt, end_busy);
    end
  endtask

  task automatic test_backpressure();
    model(4, 6);
    run_scan(4, 6, 2, -1);
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles required 0", stab_err); end
    checks++;
    if (!stream_ok()) begin errors++; $display("FAIL bp_stream: got %0d transfers required %0d", obs_q.size(), exp_q.size()); end
    checks++;
    if (busy_cnt != exp_busy + 5) begin errors++; $display("FAIL bp_busy_cycles: got %0d required %0d", busy_cnt, exp_busy + 5); end
    checks++;
    if (end_count !== 3'd1 || end_mask !== 16'h0020 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_result: got count=%0d mask=%h done=%0d required 1 0020 1", end_count, end_mask, done_cnt);
    end
  endtask

  task automatic test_boundaries();
    model(15, 15);
    run_scan(15, 15, 0, -1);
    checks++;
    if (obs_q.size() != 0 || done_cnt != 1 || end_count !== 3'd0 || end_mask !== 16'h0000) begin
      errors++;
      $display("FAIL bound_15: got primes=%0d done=%0d count=%0d mask=%h required 0 1 0 0000",
               obs_q.size(), done_cnt, end_count, end_mask);
    end
    checks++;
    if (busy_cnt != exp_busy || timed_out) begin errors++; $display("FAIL bound_15_busy: got %0d required %0d", busy_cnt, exp_busy); end
    model(13, 13);
    run_scan(13, 13, 0, -1);
    checks++;
    if (!stream_ok() || end_count !== 3'd1 || end_mask !== 16'h2000) begin
      errors++;
      $display("FAIL bound_13: got primes=%0d count=%0d mask=%h required 1 1 2000", obs_q.size(), end_count, end_mask);
    end
    checks++;
    if (busy_cnt != exp_busy || done_cnt != 1) begin errors++; $display("FAIL bound_13_busy: got %0d required %0d", busy_cnt, exp_busy); end
  endtask

  task automatic test_illegal();
    run_scan(9, 3, 0, -1);
    checks++;
    if (timed_out || done_cnt != 1 || err_cnt != 1 || err_alone != 0) begin
      errors++;
      $display("FAIL illegal_done_err: got done=%0d err=%0d err_without_done=%0d required 1 1 0", done_cnt, err_cnt, err_alone);
    end
    checks++;
    if (busy_cnt != 1) begin errors++; $display("FAIL illegal_latency: got busy cycles %0d required 1", busy_cnt); end
    checks++;
    if (obs_q.size() != 0 || end_count !== 3'd0 || end_mask !== 16'h0) begin
      errors++;
      $display("FAIL illegal_no_prime: got primes=%0d count=%0d mask=%h required 0 0 0000", obs_q.size(), end_count, end_mask);
    end
  endtask

  task automatic test_start_busy();
    model(0, 15);
    run_scan(0, 15, 0, 5);
    checks++;
    if (!stream_ok() || end_count !== 3'd6 || end_mask !== exp_mask) begin
      errors++;
      $display("FAIL busy_start: got primes=%0d count=%0d mask=%h required 6 6 %h", obs_q.size(), end_count, end_mask, exp_mask);
    end
    checks++;
    if (busy_cnt != exp_busy || done_cnt != 1) begin errors++; $display("FAIL busy_start_len: got %0d required %0d", busy_cnt, exp_busy); end
  endtask

  task automatic test_reset_mid();
    bit found;
    int post_done;
    found = 1'b0;
    post_done = 0;
    @(negedge clk);
    start = 1'b1; lo = 4'd0; hi = 4'd15; prim_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (prim_valid && prim_data == 4'd7) begin
        prim_ready = 1'b0;
        found = 1'b1;
        break;
      end
      prim_ready = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_reach_7: got no HOLD on 7 required HOLD on 7"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, prim_valid, prim_data, prim_count, prim_mask} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got busy=%b done=%b valid=%b data=%0d count=%0d mask=%h required all 0",
               busy, done, prim_valid, prim_data, prim_count, prim_mask);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) post_done++;
    end
    prim_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    if (done || busy) post_done++;
    checks++;
    if (post_done != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d busy/done cycles required 0", post_done); end
    $display("reset mid-scan on prime 7 applied");
    model(0, 3);
    run_scan(0, 3, 0, -1);
    checks++;
    if (!stream_ok() || end_count !== 3'd2 || timed_out) begin
      errors++;
      $display("FAIL rstmid_restart: got primes=%0d count=%0d required 2 2", obs_q.size(), end_count);
    end
  endtask

  task automatic test_random();
    int l, h;
    for (int it = 0; it < 12; it++) begin
      l = $urandom_range(0, 15);
      h = $urandom_range(0, 15);
      if (it % 4 == 0 && l > h) begin
        int t = l; l = h; h = t;
      end
      model(l, h);
      run_scan(l, h, 1, -1);
      checks++;
      if (timed_out || !stream_ok()) begin
        errors++;
        $display("FAIL rand_stream: lo=%0d hi=%0d got %0d primes required %0d", l, h, obs_q.size(), exp_q.size());
      end
      checks++;
      if (end_count !== 3'(exp_cnt) || end_mask !== exp_mask) begin
        errors++;
        $display("FAIL rand_stats: lo=%0d hi=%0d got count=%0d mask=%h required %0d %h", l, h, end_count, end_mask, exp_cnt, exp_mask);
      end
      checks++;
      if (done_cnt != 1 || err_cnt != ((l > h) ? 1 : 0) || stab_err != 0 || end_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_ctrl: lo=%0d hi=%0d got done=%0d err=%0d unstable=%0d busy_after=%b required 1 %0d 0 0",
                 l, h, done_cnt, err_cnt, stab_err, end_busy, (l > h) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_boundaries();
    test_illegal();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
